ex_stage: RTL
=============

# ex_stage

Execute stage of the five-stage pipelined RV32 core; it sits directly downstream of the ALU decoder and consumes its 3-bit `alu_cntrl`. The block selects ALU operands through the forwarding muxes and performs the ALU operation. It resolves branches and jumps, and registers the result plus control into the EX/MEM pipeline register. Stall and flush inputs come from the hazard unit.

## Interface
Parameters:
- `XLEN`, 32, datapath width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `stall_m` in 1: hold the EX/MEM register.
- `flush_m` in 1: load a bubble into the EX/MEM register.
- `rd1_e`, `rd2_e` in XLEN: register-file read data from ID/EX.
- `imm_ext_e`, `pc_e`, `pc_plus4_e` in XLEN: immediate, PC, and PC+4.
- `rd_e` in 5: destination register.
- `alu_src_e` in 1: select for operand B; 1 selects `imm_ext_e`.
- `alu_cntrl_e` in 3: ALU operation from the ALU decoder.
- `reg_write_e`, `mem_write_e`, `branch_e`, `jump_e` in 1: control bits.
- `result_src_e` in 2: writeback select, passed through to MEM.
- `forward_a_e`, `forward_b_e` in 2: forwarding selects from the hazard unit.
- `result_w` in XLEN: writeback-stage result used for forwarding.
- `pc_src_e` out 1: redirect fetch (combinational).
- `pc_target_e` out XLEN: branch/jump target (combinational).
- `alu_result_m`, `write_data_m`, `pc_plus4_m` out XLEN: registered outputs.
- `rd_m` out 5, `reg_write_m` out 1, `mem_write_m` out 1, `result_src_m` out 2: registered outputs.

## Operation
- Forwarding for operand A: `src_a` = `forward_a_e`: 00 → `rd1_e`, 01 → `result_w`, 10 → `alu_result_m`. Encoding 11 is treated as 00.
- Forwarding for operand B: `fwd_b` is produced from `forward_b_e` with the same encoding. `src_b` = `alu_src_e` ? `imm_ext_e` : `fwd_b`.
- ALU operations on `alu_cntrl_e`:
  - 000 ADD: `src_a + src_b`, mod 2^XLEN.
  - 001 SUB: `src_a − src_b`, mod 2^XLEN.
  - 010 AND.
  - 011 OR.
  - 101 SLT: signed compare; result is 1 or 0, zero-extended.
  - Any other code gives result 0.
- `zero` = (ALU result == 0).
- `pc_target_e` = `pc_e + imm_ext_e`, with wrap-around mod 2^XLEN.
- `pc_src_e` = (`branch_e` & `zero`) | `jump_e`. Only BEQ is supported.
- EX/MEM register, one entry, priority order:
  - `rst` → clear all fields to 0.
  - `flush_m` → clear all fields to 0 (bubble).
  - `stall_m` → hold the current contents.
  - Otherwise load the ALU result, `fwd_b` (as `write_data_m`), `pc_plus4_e`, `rd_e`, `reg_write_e`, `mem_write_e`, and `result_src_e`.
- When `flush_m` and `stall_m` are asserted together, flush wins.
- A bubble writes nothing: `reg_write_m` = 0 and `mem_write_m` = 0.
- Forwarding from `alu_result_m` always uses the currently registered value, including while stalled.
- No internal checks are made on `rd_e == 0`; the register file ignores x0 writes.

## Timing
- Reset value of every registered output is 0. Reset is asynchronous: outputs clear immediately on `rst` assertion, independent of `clk`.
- Reset takes effect mid-operation as well: any in-flight instruction is discarded.
- `pc_src_e` and `pc_target_e` are combinational, valid in the same cycle as the ID/EX inputs, and unaffected by `stall_m`/`flush_m`.
- Latency from ID/EX inputs to `*_m` outputs is 1 cycle.
- Stall holds indefinitely with no loss of data. The first edge after `stall_m` deasserts loads the new inputs.
- Combinational path: forward mux → ALU → zero → `pc_src_e`. The path is single-cycle and no internal pipelining is permitted.

## Structure
- Shared package `riscv_pkg`:
  - ALU control constants: `ALU_ADD` = 3'b000, `ALU_SUB` = 3'b001, `ALU_AND` = 3'b010, `ALU_OR` = 3'b011, `ALU_SLT` = 3'b101.
  - Forwarding select constants: `FWD_RF` = 2'b00, `FWD_WB` = 2'b01, `FWD_MEM` = 2'b10.
  - The same constants are used by the ALU decoder and the hazard unit.
- One sub-module, `alu`: purely combinational, with inputs `src_a`, `src_b`, `alu_cntrl` and outputs `result`, `zero`.
- The forwarding muxes, target adder, and EX/MEM register live in `ex_stage`.

## Test plan
- ADD then SUB: with `rd1_e` = 7 and `rd2_e` = 5, control 000 gives `alu_result_m` = 12 one cycle later; control 001 gives 2. 0 − 1 gives 0xFFFFFFFF.
- Forwarding: with `forward_a_e` = 10, `alu_result_m` = 0x10, `imm_ext_e` = 4, `alu_src_e` = 1 and ADD, the next `alu_result_m` = 0x14. With `forward_b_e` = 01 and `result_w` = 0xAB, `write_data_m` = 0xAB.
- Branch: BEQ with `rd1_e` = `rd2_e` = 3, `pc_e` = 0x100, `imm_ext_e` = 0x20 gives `pc_src_e` = 1 and `pc_target_e` = 0x120 in the same cycle. Unequal operands give `pc_src_e` = 0. `jump_e` = 1 forces `pc_src_e` = 1.
- SLT: `src_a` = 0xFFFFFFFF (−1), `src_b` = 1 → 1; swapping the operands → 0.
- Stall/flush: stall for 3 cycles and the outputs hold. With stall and flush asserted together, the next edge gives all `*_m` = 0.
- Async reset: assert `rst` between clock edges while `reg_write_m` = 1. All outputs go to 0 before the next `clk` edge and stay 0 until `rst` deasserts.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared ALU-control and forwarding-select encodings for the RV32 pipeline.
// Used by the ALU decoder, hazard unit and execute stage.
package riscv_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/alu.sv
// Combinational RV32 ALU: add/sub/and/or/signed slt, plus zero flag.
// Latency 0 cycles; no flow control.
module alu
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [2:0]      alu_cntrl,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  always_comb begin
    result = '0;
    case (alu_cntrl)
      ALU_ADD: result = src_a + src_b;
      ALU_SUB: result = src_a - src_b;
      ALU_AND: result = src_a & src_b;
      ALU_OR:  result = src_a | src_b;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch resolve, EX/MEM register.
// Latency 1 cycle to *_m; stall_m holds the register, flush_m loads a bubble (flush wins).
module ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_m,
  input  logic            flush_m,
  input  logic [XLEN-1:0] rd1_e,
  input  logic [XLEN-1:0] rd2_e,
  input  logic [XLEN-1:0] imm_ext_e,
  input  logic [XLEN-1:0] pc_e,
  input  logic [XLEN-1:0] pc_plus4_e,
  input  logic [4:0]      rd_e,
  input  logic            alu_src_e,
  input  logic [2:0]      alu_cntrl_e,
  input  logic            reg_write_e,
  input  logic            mem_write_e,
  input  logic            branch_e,
  input  logic            jump_e,
  input  logic [1:0]      result_src_e,
  input  logic [1:0]      forward_a_e,
  input  logic [1:0]      forward_b_e,
  input  logic [XLEN-1:0] result_w,
  output logic            pc_src_e,
  output logic [XLEN-1:0] pc_target_e,
  output logic [XLEN-1:0] alu_result_m,
  output logic [XLEN-1:0] write_data_m,
  output logic [XLEN-1:0] pc_plus4_m,
  output logic [4:0]      rd_m,
  output logic            reg_write_m,
  output logic            mem_write_m,
  output logic [1:0]      result_src_m
);

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic            zero;

  // Forwarding from MEM reads the registered value, so a stalled entry still forwards.
  always_comb begin
    src_a = rd1_e;
    case (forward_a_e)
      FWD_WB:  src_a = result_w;
      FWD_MEM: src_a = alu_result_m;
      default: src_a = rd1_e;
    endcase
  end

  always_comb begin
    fwd_b = rd2_e;
    case (forward_b_e)
      FWD_WB:  fwd_b = result_w;
      FWD_MEM: fwd_b = alu_result_m;
      default: fwd_b = rd2_e;
    endcase
  end

  assign src_b = alu_src_e ? imm_ext_e : fwd_b;

  alu #(.XLEN(XLEN)) u_alu (
    .src_a     (src_a),
    .src_b     (src_b),
    .alu_cntrl (alu_cntrl_e),
    .result    (alu_result),
    .zero      (zero)
  );

  assign pc_target_e = pc_e + imm_ext_e;
  assign pc_src_e    = (branch_e & zero) | jump_e;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_result_m <= '0;
      write_data_m <= '0;
      pc_plus4_m   <= '0;
      rd_m         <= '0;
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      result_src_m <= '0;
    end else if (flush_m) begin
      alu_result_m <= '0;
      write_data_m <= '0;
      pc_plus4_m   <= '0;
      rd_m         <= '0;
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      result_src_m <= '0;
    end else if (!stall_m) begin
      alu_result_m <= alu_result;
      write_data_m <= fwd_b;
      pc_plus4_m   <= pc_plus4_e;
      rd_m         <= rd_e;
      reg_write_m  <= reg_write_e;
      mem_write_m  <= mem_write_e;
      result_src_m <= result_src_e;
    end
  end

endmodule
